// File: rtl/m68k_irq_ctrl_if.sv
// 68000 bus and chip_select decode bundle for m68k_irq_ctrl.
// master = CPU/decoder side, slave = the interrupt controller.
interface m68k_irq_ctrl_if;
  logic        cpu_as_n;
  logic        cpu_rw;
  logic        cpu_lds_n;
  logic [2:0]  cpu_fc;
  logic [2:0]  cpu_a;
  logic [15:0] cpu_din;
  logic        vblank_cs;
  logic        int_en_cs;
  logic        frame_done_cs;
  logic        reset_z80_cs;
  logic [2:0]  cpu_ipl_n;
  logic        cpu_vpa_n;
  logic [15:0] vblank_dout;

  modport master (
    output cpu_as_n, cpu_rw, cpu_lds_n, cpu_fc, cpu_a, cpu_din,
           vblank_cs, int_en_cs, frame_done_cs, reset_z80_cs,
    input  cpu_ipl_n, cpu_vpa_n, vblank_dout
  );

  modport slave (
    input  cpu_as_n, cpu_rw, cpu_lds_n, cpu_fc, cpu_a, cpu_din,
           vblank_cs, int_en_cs, frame_done_cs, reset_z80_cs,
    output cpu_ipl_n, cpu_vpa_n, vblank_dout
  );
endinterface

// File: rtl/m68k_irq_ctrl.sv
// Toaplan1 68000 vblank IRQ / autovector, vblank status, sprite copy strobe and Z80 reset stretcher.
// Optional SPRITE_COPY_AUTO_EN: vblank-driven sprite copy when no frame_done write was seen that frame.

module m68k_irq_ctrl_wr_edge (
  input  logic clk_sys,
  input  logic reset,
  input  logic wr,
  output logic rise
);
  logic wr_r;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) wr_r <= 1'b0;
    else       wr_r <= wr;
  end

  assign rise = wr & ~wr_r;
endmodule

module m68k_irq_ctrl #(
  parameter int Z80_RST_CYCLES = 16,
  parameter int IRQ_LEVEL      = 4
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            vblank,
  m68k_irq_ctrl_if.slave  bus,
  output logic            sprite_copy,
  output logic            z80_reset
);
  localparam int NUM_WR = 3;
  localparam int WR_INT = 0;
  localparam int WR_FD  = 1;
  localparam int WR_Z80 = 2;

  localparam logic [2:0] LVL      = 3'(IRQ_LEVEL);
  localparam logic [7:0] RST_LOAD = 8'(Z80_RST_CYCLES);

  logic [NUM_WR-1:0] cs_vec, wr, wr_rise;
  logic              wr_strobe;
  logic              vblank_r, vb_rise;
  logic              int_en, irq_pending, pending_nxt;
  logic              iack;
  logic [2:0]        ipl_q;
  logic              copy_req;
  logic [7:0]        z80_cnt;
  logic [7:0]        unused_din;

  assign unused_din = bus.cpu_din[15:8];

  assign wr_strobe = ~bus.cpu_rw & ~bus.cpu_lds_n;
  assign cs_vec    = {bus.reset_z80_cs, bus.frame_done_cs, bus.int_en_cs};
  assign wr        = cs_vec & {NUM_WR{wr_strobe}};

  // One edge detector per writable decode so a held bus cycle acts once.
  for (genvar g = 0; g < NUM_WR; g++) begin : g_wr
    m68k_irq_ctrl_wr_edge u_edge (
      .clk_sys (clk_sys),
      .reset   (reset),
      .wr      (wr[g]),
      .rise    (wr_rise[g])
    );
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) vblank_r <= 1'b0;
    else       vblank_r <= vblank;
  end

  assign vb_rise = vblank & ~vblank_r;
  assign iack    = (bus.cpu_fc == 3'b111) & ~bus.cpu_as_n & (bus.cpu_a == LVL);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)               int_en <= 1'b0;
    else if (wr_rise[WR_INT]) int_en <= bus.cpu_din[0];
  end

  // Set beats clear, so a vblank edge landing on an IACK is not lost.
  always_comb begin
    pending_nxt = irq_pending;
    if (iack | (wr_rise[WR_INT] & ~bus.cpu_din[0])) pending_nxt = 1'b0;
    if (vb_rise & int_en)                          pending_nxt = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      irq_pending <= 1'b0;
      ipl_q       <= 3'b111;
    end else begin
      irq_pending <= pending_nxt;
      ipl_q       <= pending_nxt ? ~LVL : 3'b111;
    end
  end

  assign bus.cpu_ipl_n   = ipl_q;
  assign bus.cpu_vpa_n   = ~(iack & ~reset);
  assign bus.vblank_dout = bus.vblank_cs ? {15'b0, vblank_r} : 16'h0000;

`ifdef SPRITE_COPY_AUTO_EN
  logic seen_fd;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                seen_fd <= 1'b0;
    else if (wr_rise[WR_FD])  seen_fd <= 1'b1;
    else if (vb_rise)         seen_fd <= 1'b0;
  end

  assign copy_req = wr_rise[WR_FD] | (vb_rise & ~seen_fd);
`else
  assign copy_req = wr_rise[WR_FD];
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) sprite_copy <= 1'b0;
    else       sprite_copy <= copy_req;
  end

  // Counter comes out of reset loaded, giving the power-on Z80 reset pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      z80_cnt <= RST_LOAD;
    else if (wr_rise[WR_Z80] && bus.cpu_din[7:0] == 8'h00)
      z80_cnt <= RST_LOAD;
    else if (z80_cnt != 8'h00)
      z80_cnt <= z80_cnt - 8'h01;
  end

  assign z80_reset = (z80_cnt != 8'h00);
endmodule

// File: tb/tb_m68k_irq_ctrl.sv
// Scoreboard bench for m68k_irq_ctrl: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_m68k_irq_ctrl;
`ifdef SPRITE_COPY_AUTO_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif
  localparam int F_IPL = 0, F_VPA = 1, F_DOUT = 2, F_SC = 3, F_ZR = 4;
  localparam int WR_INT = 0, WR_FD = 1, WR_Z80 = 2;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic vblank  = 1'b0;
  logic sprite_copy, z80_reset;

  m68k_irq_ctrl_if bus ();

  m68k_irq_ctrl #(.Z80_RST_CYCLES(16), .IRQ_LEVEL(4)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .vblank      (vblank),
    .bus         (bus.slave),
    .sprite_copy (sprite_copy),
    .z80_reset   (z80_reset)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       nm;
    int          fld;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(string nm, int fld, logic [15:0] val);
    exp_t e;
    e.nm = nm; e.fld = fld; e.val = val;
    sb.push_back(e);
  endtask

  // Monitor: everything queued since the last edge is checked on this negedge.
  always @(negedge clk_sys) begin
    exp_t        e;
    logic [15:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.fld)
        F_IPL:   act = {13'b0, bus.cpu_ipl_n};
        F_VPA:   act = {15'b0, bus.cpu_vpa_n};
        F_DOUT:  act = bus.vblank_dout;
        F_SC:    act = {15'b0, sprite_copy};
        default: act = {15'b0, z80_reset};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", e.nm, act, e.val, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  task automatic idle();
    bus.cpu_as_n = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_lds_n = 1'b1;
    bus.cpu_fc = 3'd0; bus.cpu_a = 3'd0; bus.cpu_din = 16'h0000;
    bus.vblank_cs = 1'b0; bus.int_en_cs = 1'b0;
    bus.frame_done_cs = 1'b0; bus.reset_z80_cs = 1'b0;
  endtask

  task automatic drive_wr(int which, logic [15:0] d);
    idle();
    bus.cpu_as_n = 1'b0; bus.cpu_rw = 1'b0; bus.cpu_lds_n = 1'b0; bus.cpu_din = d;
    case (which)
      WR_INT:  bus.int_en_cs     = 1'b1;
      WR_FD:   bus.frame_done_cs = 1'b1;
      default: bus.reset_z80_cs  = 1'b1;
    endcase
  endtask

  task automatic write_once(int which, logic [15:0] d);
    drive_wr(which, d);
    step();
    idle();
  endtask

  task automatic drive_iack(logic [2:0] lvl);
    idle();
    bus.cpu_fc = 3'b111; bus.cpu_a = lvl; bus.cpu_as_n = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    step(); step();
    expect_v("rst_ipl", F_IPL, 16'h0007);
    expect_v("rst_vpa", F_VPA, 16'h0001);
    expect_v("rst_sc",  F_SC,  16'h0000);
    expect_v("rst_zr",  F_ZR,  16'h0001);
    step();

    // Power-on Z80 pulse: 16 cycles from reset release.
    reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      expect_v("post_rst_zr", F_ZR, (i < 16) ? 16'h0001 : 16'h0000);
      if (i == 0) expect_v("post_rst_dout", F_DOUT, 16'h0000);
      step();
    end

    // Enabled IRQ path and IACK.
    write_once(WR_INT, 16'h0001);
    vblank = 1'b1;
    expect_v("ipl_before_rise", F_IPL, 16'h0007);
    step();
    expect_v("ipl_vb_rise", F_IPL, 16'h0003);
    expect_v("sc_vb_rise",  F_SC,  {15'b0, AUTO});
    step();
    drive_iack(3'd4);
    expect_v("iack_vpa", F_VPA, 16'h0000);
    expect_v("iack_ipl_hold", F_IPL, 16'h0003);
    step();
    idle();
    expect_v("post_iack_vpa", F_VPA, 16'h0001);
    expect_v("post_iack_ipl", F_IPL, 16'h0007);
    step();
    bus.vblank_cs = 1'b1; bus.cpu_as_n = 1'b0; bus.cpu_lds_n = 1'b0;
    expect_v("vb_read", F_DOUT, 16'h0001);
    step();
    idle();
    expect_v("vb_nocs", F_DOUT, 16'h0000);
    step();
    vblank = 1'b0;
    step();

    // Set/clear collision, then a wrong-level IACK, then the real one.
    vblank = 1'b1;
    drive_iack(3'd4);
    expect_v("coll_vpa", F_VPA, 16'h0000);
    step();
    idle();
    expect_v("coll_ipl", F_IPL, 16'h0003);
    step();
    drive_iack(3'd3);
    expect_v("wrong_lvl_vpa", F_VPA, 16'h0001);
    step();
    idle();
    expect_v("wrong_lvl_ipl", F_IPL, 16'h0003);
    drive_iack(3'd4);
    step();
    idle();
    expect_v("coll_cleared", F_IPL, 16'h0007);
    step();
    vblank = 1'b0;
    step();

    // Disabled IRQ: three rises, no IPL.
    write_once(WR_INT, 16'h0000);
    for (int r = 0; r < 3; r++) begin
      vblank = 1'b1;
      step();
      expect_v("dis_ipl", F_IPL, 16'h0007);
      expect_v("dis_sc",  F_SC,  {15'b0, AUTO});
      step();
      vblank = 1'b0;
      expect_v("dis_sc_off", F_SC, 16'h0000);
      step();
    end

    // Enable mid-vblank: only the next rise interrupts.
    vblank = 1'b1;
    step(); step();
    write_once(WR_INT, 16'h0001);
    for (int i = 0; i < 2; i++) begin
      expect_v("en_mid_vblank", F_IPL, 16'h0007);
      step();
    end
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    step();
    expect_v("en_next_rise", F_IPL, 16'h0003);
    step();
    drive_iack(3'd4);
    step();
    idle();
    vblank = 1'b0;
    expect_v("en_cleared", F_IPL, 16'h0007);
    step();

    // Z80 reset pulse.
    drive_wr(WR_Z80, 16'h0000);
    expect_v("z80_pre", F_ZR, 16'h0000);
    step();
    idle();
    for (int i = 0; i <= 16; i++) begin
      expect_v("z80_pulse", F_ZR, (i < 16) ? 16'h0001 : 16'h0000);
      step();
    end
    write_once(WR_Z80, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      expect_v("z80_nonzero", F_ZR, 16'h0000);
      step();
    end
    write_once(WR_Z80, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      expect_v("z80_first", F_ZR, 16'h0001);
      step();
    end
    write_once(WR_Z80, 16'h0000);
    for (int i = 0; i <= 16; i++) begin
      expect_v("z80_retrig", F_ZR, (i < 16) ? 16'h0001 : 16'h0000);
      step();
    end

    // Held frame_done write: one pulse.
    drive_wr(WR_FD, 16'hbeef);
    expect_v("fd_held_pre", F_SC, 16'h0000);
    step();
    for (int k = 1; k <= 4; k++) begin
      expect_v("fd_held", F_SC, (k == 1) ? 16'h0001 : 16'h0000);
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      expect_v("fd_after", F_SC, 16'h0000);
      step();
    end

`ifdef SPRITE_COPY_AUTO_EN
    // A frame_done write this frame suppresses the next auto copy only.
    vblank = 1'b1;
    step();
    expect_v("auto_seen_fd", F_SC, 16'h0000);
    step();
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    step();
    expect_v("auto_resume", F_SC, 16'h0001);
    step();
    vblank = 1'b0;
    step();
`endif

    // frame_done write coinciding with a vblank rise: single pulse.
    write_once(WR_INT, 16'h0001);
    drive_wr(WR_FD, 16'h0000);
    vblank = 1'b1;
    step();
    idle();
    expect_v("coinc_sc", F_SC, 16'h0001);
    expect_v("coinc_ipl", F_IPL, 16'h0003);
    step();
    expect_v("coinc_sc_once", F_SC, 16'h0000);
    step();
    vblank = 1'b0;
    step();

    // Asynchronous reset while IRQ pending and sprite_copy high.
    drive_wr(WR_FD, 16'h0000);
    vblank = 1'b1;
    step();
    idle();
    #1 reset = 1'b1;
    expect_v("rst_mid_ipl", F_IPL, 16'h0007);
    expect_v("rst_mid_sc",  F_SC,  16'h0000);
    expect_v("rst_mid_zr",  F_ZR,  16'h0001);
    expect_v("rst_mid_vpa", F_VPA, 16'h0001);
    step(); step();
    reset = 1'b0;
    step();
    expect_v("post_rst_noirq", F_IPL, 16'h0007);
    expect_v("post_rst_zr2",   F_ZR,  16'h0001);
    step();
    vblank = 1'b0;
    step(); step();

    @(negedge clk_sys); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
